module_pipe_stall_ctrl: RTL
===========================

// Module: module_pipe_stall_ctrl
// PURPOSE
//  Drives the enable/clear inputs of every enable-flop pipeline register (F/D, D/E, E/M, M/W) of the RV32I core.
//  Combines load-use hazard detection, branch flush, and a multi-cycle data-memory handshake FSM.
//  The FSM freezes the pipeline until the memory acknowledges.
//  Sits beside the forwarding unit; owns all stall/flush decisions plus a stall-cycle performance counter.
// PARAMETERS
//  TIMEOUT   16  max WAIT cycles before memory error is declared (>=1)
//  CNT_W     32  width of stall performance counter
// PORTS
//  clk_i         in   1      clock
//  rst_i         in   1      reset, asynchronous, active-high
//  rs1_d_i       in   5      rs1 of instruction in Decode
//  rs2_d_i       in   5      rs2 of instruction in Decode
//  rd_e_i        in   5      rd of instruction in Execute
//  load_e_i      in   1      instruction in Execute is a load
//  pcsrc_e_i     in   1      branch/jump taken, resolved in Execute
//  memop_m_i     in   1      load/store present in Memory stage
//  mem_ack_i     in   1      data memory acknowledges current request
//  mem_req_o     out  1      request to data memory
//  en_f_o        out  1      PC register enable
//  en_d_o        out  1      F/D register enable
//  en_e_o        out  1      D/E register enable
//  en_m_o        out  1      E/M register enable
//  clr_d_o       out  1      F/D synchronous clear (bubble)
//  clr_e_o       out  1      D/E synchronous clear (bubble)
//  clr_w_o       out  1      M/W synchronous clear (bubble)
//  mem_err_o     out  1      sticky memory-timeout error
//  stall_cnt_o   out  CNT_W  count of cycles with en_f_o==0
// BEHAVIOUR
//  FSM states: IDLE, WAIT, ERR. Reset -> IDLE, wait counter 0, stall_cnt_o 0, mem_err_o 0.
//  While rst_i=1: mem_req_o=0, all en_*=0, all clr_*=1.
//  mem_req_o = memop_m_i in IDLE; 1 in WAIT; 0 in ERR.
//  mem_stall = (IDLE & memop_m_i & ~mem_ack_i) | (WAIT & ~mem_ack_i) | ERR.
//  IDLE: memop & ack same cycle -> zero-wait access, no stall. memop & ~ack -> WAIT, wait counter = 1.
//  WAIT: ack -> IDLE, pipeline advances in that same cycle. No ack -> counter +1.
//  WAIT -> ERR: when counter == TIMEOUT and there is no ack.
//  ERR: terminal until reset. mem_err_o=1 registered on entry; pipeline frozen.
//  lw_stall = load_e_i & (rd_e_i!=0) & ((rd_e_i==rs1_d_i)|(rd_e_i==rs2_d_i)).
//  Priority mem_stall > lw_stall > branch. All outputs except mem_err_o/stall_cnt_o are combinational.
//   mem_stall: en_f=en_d=en_e=en_m=0, clr_d=clr_e=0, clr_w=1; lw_stall and pcsrc_e are ignored that cycle.
//   otherwise: en_m=en_e=1, clr_w=0.
//    en_f=en_d=~lw_stall.
//    clr_e = lw_stall | pcsrc_e_i.
//    clr_d = pcsrc_e_i.
//  lw_stall and pcsrc_e together: F/D held and cleared (branch wins for the flushed slot), D/E cleared.
//  stall_cnt_o: +1 on every cycle with en_f_o==0 (rst_i low). Saturates at all-ones, never wraps.
//  Async reset mid-WAIT: state->IDLE, request dropped immediately. A late mem_ack_i in IDLE without memop is ignored.
// TESTING
//  1. Reset, then lw x5 in E, rs1_d=5 -> en_f=en_d=0, clr_e=1 for 1 cycle; rd_e=0 with rs1_d=0 -> no stall.
//  2. pcsrc_e=1 with no hazard -> clr_d=clr_e=1, all en=1 for exactly 1 cycle.
//  3. memop_m=1, ack after 3 cycles -> mem_req high 3 cycles; en_* low 2 cycles + clr_w=1; stall_cnt_o=2.
//  4. memop with ack same cycle -> no stall; state stays IDLE; stall_cnt_o unchanged.
//  5. TIMEOUT=4, ack never -> ERR after 5th cycle; mem_err_o=1, pipeline frozen until rst_i.
//  6. mem_stall with lw_stall+pcsrc_e; rst_i pulsed mid-WAIT; CNT_W=4 over 20 stalls -> memory priority, IDLE+req=0, count held at 15.

Source files
------------

// File: rtl/module_pipe_stall_ctrl.sv
// Stall/flush controller for the RV32I pipeline: load-use hazards, branch flush,
// and a data-memory handshake FSM with timeout, plus a stall-cycle counter.
module module_pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rd_e_i,
  input  logic             load_e_i,
  input  logic             pcsrc_e_i,
  input  logic             memop_m_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             en_f_o,
  output logic             en_d_o,
  output logic             en_e_o,
  output logic             en_m_o,
  output logic             clr_d_o,
  output logic             clr_e_o,
  output logic             clr_w_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_stall;
  logic            lw_stall;

  always_comb begin
    mem_stall = 1'b0;
    mem_req_o = 1'b0;
    case (state)
      S_IDLE: begin
        mem_stall = memop_m_i & ~mem_ack_i;
        mem_req_o = memop_m_i;
      end
      S_WAIT: begin
        mem_stall = ~mem_ack_i;
        mem_req_o = 1'b1;
      end
      default: begin
        mem_stall = 1'b1;
        mem_req_o = 1'b0;
      end
    endcase
    if (rst_i) mem_req_o = 1'b0;
  end

  assign lw_stall = load_e_i && (rd_e_i != 5'd0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // Memory stall freezes everything and bubbles M/W; hazard and branch wait their turn.
  always_comb begin
    en_f_o  = 1'b0;
    en_d_o  = 1'b0;
    en_e_o  = 1'b0;
    en_m_o  = 1'b0;
    clr_d_o = 1'b1;
    clr_e_o = 1'b1;
    clr_w_o = 1'b1;
    if (!rst_i) begin
      if (mem_stall) begin
        clr_d_o = 1'b0;
        clr_e_o = 1'b0;
        clr_w_o = 1'b1;
      end else begin
        en_f_o  = ~lw_stall;
        en_d_o  = ~lw_stall;
        en_e_o  = 1'b1;
        en_m_o  = 1'b1;
        clr_d_o = pcsrc_e_i;
        clr_e_o = lw_stall | pcsrc_e_i;
        clr_w_o = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_err_o   <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (memop_m_i && !mem_ack_i) begin
            state    <= S_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_W'(TIMEOUT)) begin
            state     <= S_ERR;
            mem_err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        default: state <= S_ERR;
      endcase
      if (!en_f_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
